// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler: latches hall/cabin button pulses into pending-call lamps,
// runs the collective direction FSM and registers the next stop for the controller.
module elevator_call_scheduler #(
  parameter int FLOORS  = 8,
  parameter int LEVEL_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-1:0]  btn_up_out,
  input  logic [FLOORS-1:0]  btn_down_out,
  input  logic [LEVEL_W-1:0] level,
  input  logic               door_open,
  input  logic               moving,
  output logic [FLOORS-1:0]  pend_in,
  output logic [FLOORS-1:0]  pend_up,
  output logic [FLOORS-1:0]  pend_down,
  output logic [1:0]         dir,
  output logic [LEVEL_W-1:0] target,
  output logic               target_valid
);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  localparam logic [FLOORS-1:0] UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DOWN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0]  pend_in_q, pend_up_q, pend_down_q;
  logic [FLOORS-1:0]  pend_in_d, pend_up_d, pend_down_d;
  dir_e               dir_q, dir_d;
  logic [LEVEL_W-1:0] target_q, target_d;
  logic               valid_q, valid_d;

  logic [FLOORS-1:0]  gt_s, lt_s, eq_s, any_s;
  logic [FLOORS-1:0]  up_pri_s, up_alt_s, dn_pri_s, dn_alt_s;
  logic [LEVEL_W-1:0] up_pri_idx_s, up_alt_idx_s, dn_pri_idx_s, dn_alt_idx_s;
  logic               above_s, below_s, here_s;

  // Floor position relative to the car, and the four stop-candidate encoders
  always_comb begin
    gt_s = '0;
    lt_s = '0;
    eq_s = '0;
    up_pri_idx_s = '0;
    up_alt_idx_s = '0;
    dn_pri_idx_s = '0;
    dn_alt_idx_s = '0;
    for (int i = 0; i < FLOORS; i++) begin
      gt_s[i] = (LEVEL_W'(i) > level);
      lt_s[i] = (LEVEL_W'(i) < level);
      eq_s[i] = (LEVEL_W'(i) == level);
    end
    any_s    = pend_in_q | pend_up_q | pend_down_q;
    up_pri_s = (pend_in_q | pend_up_q) & gt_s;
    up_alt_s = pend_down_q & gt_s;
    dn_pri_s = (pend_in_q | pend_down_q) & lt_s;
    dn_alt_s = pend_up_q & lt_s;
    // Descending scans leave the lowest hit, ascending scans the highest
    for (int i = FLOORS - 1; i >= 0; i--) begin
      up_pri_idx_s = up_pri_s[i] ? LEVEL_W'(i) : up_pri_idx_s;
      dn_alt_idx_s = dn_alt_s[i] ? LEVEL_W'(i) : dn_alt_idx_s;
    end
    for (int i = 0; i < FLOORS; i++) begin
      up_alt_idx_s = up_alt_s[i] ? LEVEL_W'(i) : up_alt_idx_s;
      dn_pri_idx_s = dn_pri_s[i] ? LEVEL_W'(i) : dn_pri_idx_s;
    end
    above_s = |(any_s & gt_s);
    below_s = |(any_s & lt_s);
    here_s  = |(any_s & eq_s);
  end

  // Call capture; an open door at this floor wins over a simultaneous press
  always_comb begin
    pend_in_d   = (pend_in_q | btn_in) & ~(eq_s & {FLOORS{door_open}});
    pend_up_d   = (pend_up_q | (btn_up_out & UP_MASK))
                & ~(eq_s & {FLOORS{door_open && (dir_q != DIR_DOWN)}});
    pend_down_d = (pend_down_q | (btn_down_out & DOWN_MASK))
                & ~(eq_s & {FLOORS{door_open && (dir_q != DIR_UP)}});
  end

  // Direction FSM, frozen while the car is moving
  always_comb begin
    dir_d = dir_q;
    if (moving) begin
      dir_d = dir_q;
    end else begin
      case (dir_q)
        DIR_IDLE: dir_d = above_s ? DIR_UP   : (below_s ? DIR_DOWN : DIR_IDLE);
        DIR_UP:   dir_d = above_s ? DIR_UP   : (below_s ? DIR_DOWN : DIR_IDLE);
        DIR_DOWN: dir_d = below_s ? DIR_DOWN : (above_s ? DIR_UP   : DIR_IDLE);
        default:  dir_d = DIR_IDLE;
      endcase
    end
  end

  // Next stop: same-direction calls first, else the farthest reversal call
  always_comb begin
    target_d = level;
    case (dir_d)
      DIR_UP:   target_d = (|up_pri_s) ? up_pri_idx_s : ((|up_alt_s) ? up_alt_idx_s : level);
      DIR_DOWN: target_d = (|dn_pri_s) ? dn_pri_idx_s : ((|dn_alt_s) ? dn_alt_idx_s : level);
      default:  target_d = level;
    endcase
    valid_d = (dir_d != DIR_IDLE) | here_s;
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_in_q   <= '0;
      pend_up_q   <= '0;
      pend_down_q <= '0;
      dir_q       <= DIR_IDLE;
      target_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      pend_in_q   <= pend_in_d;
      pend_up_q   <= pend_up_d;
      pend_down_q <= pend_down_d;
      dir_q       <= dir_d;
      target_q    <= target_d;
      valid_q     <= valid_d;
    end
  end

  assign pend_in      = pend_in_q;
  assign pend_up      = pend_up_q;
  assign pend_down    = pend_down_q;
  assign dir          = dir_q;
  assign target       = target_q;
  assign target_valid = valid_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: directed scenarios plus randomized traffic
// compared against a floor-by-floor behavioural model of the SCAN rules.
module tb_elevator_call_scheduler;
  localparam int F = 8;
  localparam int LW = 3;

  logic          clk, reset, door_open, moving;
  logic [F-1:0]  btn_in, btn_up_out, btn_down_out;
  logic [LW-1:0] level;
  logic [F-1:0]  pend_in, pend_up, pend_down;
  logic [1:0]    dir;
  logic [LW-1:0] target;
  logic          target_valid;

  int n_checks = 0;
  int n_errors = 0;

  bit [F-1:0] m_in, m_up, m_down;
  int m_dir, m_tgt;
  bit m_valid;

  elevator_call_scheduler #(.FLOORS(F), .LEVEL_W(LW)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out), .level(level), .door_open(door_open),
    .moving(moving), .pend_in(pend_in), .pend_up(pend_up), .pend_down(pend_down),
    .dir(dir), .target(target), .target_valid(target_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_in = '0; m_up = '0; m_down = '0;
    m_dir = 0; m_tgt = 0; m_valid = 1'b0;
  endfunction

  // One clock of the scheduling rules (0 idle, 1 up, 2 down)
  function automatic void model_step();
    int lv, nd, t;
    bit [F-1:0] n_in, n_up, n_down;
    bit above, below, here, found, served, any;
    lv = int'(level);
    above = 0; below = 0; here = 0;
    for (int f = 0; f < F; f++) begin
      served = door_open && (f == lv);
      any = m_in[f] || m_up[f] || m_down[f];
      n_in[f]   = (m_in[f] || btn_in[f]) && !served;
      n_up[f]   = (m_up[f] || (btn_up_out[f] && f != F - 1)) && !(served && m_dir != 2);
      n_down[f] = (m_down[f] || (btn_down_out[f] && f != 0)) && !(served && m_dir != 1);
      if (any && f > lv) above = 1;
      if (any && f < lv) below = 1;
      if (any && f == lv) here = 1;
    end
    if (moving) nd = m_dir;
    else if (m_dir == 2) nd = below ? 2 : (above ? 1 : 0);
    else nd = above ? 1 : (below ? 2 : 0);
    t = lv; found = 0;
    if (nd == 1) begin
      for (int f = lv + 1; f < F; f++)
        if (!found && (m_in[f] || m_up[f])) begin t = f; found = 1; end
      for (int f = F - 1; f > lv; f--)
        if (!found && m_down[f]) begin t = f; found = 1; end
    end else if (nd == 2) begin
      for (int f = lv - 1; f >= 0; f--)
        if (!found && (m_in[f] || m_down[f])) begin t = f; found = 1; end
      for (int f = 0; f < lv; f++)
        if (!found && m_up[f]) begin t = f; found = 1; end
    end
    m_in = n_in; m_up = n_up; m_down = n_down;
    m_dir = nd; m_tgt = t; m_valid = (nd != 0) || here;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    door_open = 1'b0; moving = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    level = '0;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pend_in, pend_up, pend_down, dir, target, target_valid} !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected 0",
               {pend_in, pend_up, pend_down, dir, target, target_valid});
    end
    do_reset();
  endtask

  task automatic test_basic_up();
    do_reset();
    clear_inputs(); level = 3'd0;
    btn_in = 8'h80;
    tick();
    btn_in = '0;
    n_checks++;
    if (pend_in !== 8'h80) begin n_errors++; $display("FAIL basic_lamp: got %h expected 80", pend_in); end
    n_checks++;
    if (dir !== 2'b00) begin n_errors++; $display("FAIL basic_dir_latency: got %b expected 00", dir); end
    tick();
    n_checks++;
    if ({dir, target, target_valid} !== {2'b01, 3'd7, 1'b1}) begin
      n_errors++; $display("FAIL basic_target: got dir=%b tgt=%0d v=%b expected 01/7/1", dir, target, target_valid);
    end
  endtask

  task automatic test_stop_reverse();
    do_reset();
    clear_inputs(); level = 3'd0;
    btn_in = 8'h20; btn_down_out = 8'h08;
    tick();
    btn_in = '0; btn_down_out = '0;
    tick();
    n_checks++;
    if ({dir, target} !== {2'b01, 3'd5}) begin
      n_errors++; $display("FAIL reverse_first_stop: got dir=%b tgt=%0d expected 01/5", dir, target);
    end
    moving = 1'b1; level = 3'd5;
    tick();
    moving = 1'b0; door_open = 1'b1;
    tick();
    door_open = 1'b0;
    n_checks++;
    if (pend_in[5] !== 1'b0) begin n_errors++; $display("FAIL reverse_clear: got %b expected 0", pend_in[5]); end
    n_checks++;
    if ({dir, target, target_valid} !== {2'b10, 3'd3, 1'b1}) begin
      n_errors++; $display("FAIL reverse_dir: got dir=%b tgt=%0d v=%b expected 10/3/1", dir, target, target_valid);
    end
  endtask

  task automatic test_open_door_press();
    do_reset();
    clear_inputs(); level = 3'd2; door_open = 1'b1;
    btn_up_out = 8'h04; btn_in = 8'h04;
    tick();
    btn_up_out = '0; btn_in = '0;
    n_checks++;
    if ({pend_in[2], pend_up[2]} !== 2'b00) begin
      n_errors++; $display("FAIL open_door_press: got %b expected 00", {pend_in[2], pend_up[2]});
    end
    tick();
    door_open = 1'b0;
    n_checks++;
    if ({dir, target_valid} !== 3'b000) begin
      n_errors++; $display("FAIL open_door_valid: got dir=%b v=%b expected 00/0", dir, target_valid);
    end
  endtask

  task automatic test_masked();
    do_reset();
    clear_inputs(); level = 3'd3;
    btn_up_out = 8'h80; btn_down_out = 8'h01;
    tick();
    clear_inputs();
    n_checks++;
    if ({pend_up, pend_down} !== 16'h0000) begin
      n_errors++; $display("FAIL masked_lamps: got %h expected 0000", {pend_up, pend_down});
    end
    tick();
    n_checks++;
    if ({dir, target_valid} !== 3'b000) begin
      n_errors++; $display("FAIL masked_dir: got dir=%b v=%b expected 00/0", dir, target_valid);
    end
  endtask

  task automatic test_moving_hold();
    do_reset();
    clear_inputs(); level = 3'd3;
    btn_in = 8'h20;
    tick();
    btn_in = '0;
    tick();
    moving = 1'b1; level = 3'd5; door_open = 1'b1; btn_in = 8'h02;
    tick();
    door_open = 1'b0; btn_in = '0; level = 3'd3;
    tick();
    tick();
    n_checks++;
    if ({dir, pend_in} !== {2'b01, 8'h02}) begin
      n_errors++; $display("FAIL moving_hold: got dir=%b pend_in=%h expected 01/02", dir, pend_in);
    end
    moving = 1'b0;
    tick();
    n_checks++;
    if ({dir, target} !== {2'b10, 3'd1}) begin
      n_errors++; $display("FAIL moving_release: got dir=%b tgt=%0d expected 10/1", dir, target);
    end
  endtask

  task automatic test_async_reset();
    clear_inputs(); level = 3'd4;
    btn_in = 8'h81; btn_up_out = 8'h02; btn_down_out = 8'h40;
    tick();
    clear_inputs();
    tick();
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pend_in, pend_up, pend_down, dir, target, target_valid} !== '0) begin
      n_errors++; $display("FAIL async_reset: got %h expected 0",
                           {pend_in, pend_up, pend_down, dir, target, target_valid});
    end
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    int lv;
    do_reset();
    clear_inputs(); level = 3'd0; lv = 0;
    for (int c = 0; c < 2000; c++) begin
      btn_in       = 8'($urandom & $urandom & $urandom);
      btn_up_out   = 8'($urandom & $urandom & $urandom);
      btn_down_out = 8'($urandom & $urandom & $urandom);
      door_open    = ($urandom_range(0, 4) == 0);
      moving       = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if (lv == F - 1 || (lv > 0 && $urandom_range(0, 1) == 0)) lv = lv - 1;
        else lv = lv + 1;
      end
      level = LW'(lv);
      if (c == 1000) do_reset();
      tick();
      n_checks++;
      if ({pend_in, pend_up, pend_down} !== {m_in, m_up, m_down}) begin
        n_errors++; $display("FAIL rand_pend c=%0d: got %h expected %h", c,
                             {pend_in, pend_up, pend_down}, {m_in, m_up, m_down});
      end
      n_checks++;
      if (dir !== 2'(m_dir)) begin
        n_errors++; $display("FAIL rand_dir c=%0d: got %b expected %0d", c, dir, m_dir);
      end
      n_checks++;
      if ({target, target_valid} !== {LW'(m_tgt), m_valid}) begin
        n_errors++; $display("FAIL rand_target c=%0d: got %0d/%b expected %0d/%b", c,
                             target, target_valid, m_tgt, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_up();
    test_stop_reverse();
    test_open_door_press();
    test_masked();
    test_moving_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Upstream request stage for the `elevator` controller. It latches single-cycle hall and cabin button pulses into pending-call registers and drives the call lamps. It runs a SCAN (collective) direction state machine from the car's current floor, and presents the next stop floor and travel direction to the motion/door controller. Pending calls are cleared when the controller reports the door open at a floor.

## Interface

Parameters:
- `FLOORS`, 8: number of floors; sets the width of every button and lamp vector.
- `LEVEL_W`, 3: floor-index width; must satisfy FLOORS <= 2**LEVEL_W.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_in` in FLOORS: cabin buttons; one-cycle pulses, bit i = floor i.
- `btn_up_out` in FLOORS: hall up buttons; bit FLOORS-1 is ignored.
- `btn_down_out` in FLOORS: hall down buttons; bit 0 is ignored.
- `level` in LEVEL_W: current car floor from the controller's `level_display`; always < FLOORS.
- `door_open` in 1: 1 while the door is open at `level`; this is the service event.
- `moving` in 1: 1 while the engine is driving, i.e. engine != 0.
- `pend_in`, `pend_up`, `pend_down` out FLOORS: pending-call registers, also used as lamp drives.
- `dir` out 2: 00 IDLE, 01 UP, 10 DOWN. Code 11 is never produced.
- `target` out LEVEL_W: next stop floor.
- `target_valid` out 1: `target` is meaningful.

## Operation

- **Capture.** Each cycle: `pend_X <= (pend_X | btn_X) & ~clr_X`. `btn_up_out[FLOORS-1]` and `btn_down_out[0]` are masked to 0.
- **Clear.** Clearing happens only when `door_open=1`, and only at index `level`:
  - `clr_in[level]` is always asserted.
  - `clr_up[level]` is asserted when `dir != DOWN`.
  - `clr_down[level]` is asserted when `dir != UP`.
  - A press and a clear on the same bit in the same cycle: the clear wins, because the call is served by the already-open door.
- **Derived terms** (combinational, from the registered pend vectors):
  - `above` = any pending bit at a floor > `level`.
  - `below` = any pending bit at a floor < `level`.
  - `here` = any pending bit at `level`.
- **Direction FSM.** It may change only while `moving=0`; while `moving=1`, `dir` holds.
  - IDLE: `above` -> UP; else `below` -> DOWN; else stay IDLE. When both are set, UP wins.
  - UP: `above` -> stay UP; else `below` -> DOWN; else IDLE.
  - DOWN: `below` -> stay DOWN; else `above` -> UP; else IDLE.
- **Target selection** (registered, computed from the same cycle's pend state and next `dir`):
  - UP: the lowest floor > `level` with `pend_in | pend_up` set. If there is none, the highest floor > `level` with `pend_down` set.
  - DOWN: the highest floor < `level` with `pend_in | pend_down` set. If there is none, the lowest floor < `level` with `pend_up` set.
  - IDLE: `target = level`, `target_valid = here`. This asks the controller to open the door in place.
  - `target_valid = (next dir != IDLE) | here`.
- **Priority encoders** are loops over FLOORS and are fully parametric. No arithmetic on `level` beyond comparisons.

## Timing

- **Reset** (asynchronous, when `reset=0`): all pend vectors = 0, `dir` = IDLE, `target` = 0, `target_valid` = 0. The outputs change immediately, not at the next clock edge.
- **Reset released mid-travel:** all calls are lost, and the scheduler restarts IDLE at whatever `level` reads.
- **Button to lamp:** a pulse sampled at edge N shows on `pend_*` after edge N. Latency is 1 cycle.
- **Button to target:** `dir`, `target` and `target_valid` reflect that press after edge N+1. Latency is 2 cycles.
- **Door open to lamp off:** `door_open` sampled at edge N clears the bit after edge N.
- **Dependence on `level`:** `target` reflects a new `level` one cycle after `level` changes.
- **Held buttons:** a button held high for several cycles sets its bit and keeps it set. While `door_open=1` at that floor, the bit is re-cleared every cycle.
- **Moving hold:** `target` may still update while `moving=1`, for example when a nearer call in the same direction appears. Only `dir` is frozen.

## Test plan

1. **Basic up call.** Reset. Set `level=0`, `moving=0`, and pulse `btn_in[7]`.
   - Next cycle: `pend_in=8'h80`.
   - One cycle later: `dir=01`, `target=7`, `target_valid=1`.
2. **Stop, then reverse.** Start at `level=0`, `dir=UP`. Pulse `btn_in[5]` and `btn_down_out[3]` together.
   - `target=5`.
   - Drive `level=5`, then pulse `door_open=1` with `moving=0`: `pend_in[5]` clears, then `dir=10`, `target=3`.
3. **Press during open door.** With `dir=IDLE`, `level=2`, `door_open=1`, pulse `btn_up_out[2]` and `btn_in[2]`.
   - Both bits stay 0, `target_valid=0`.
4. **Masked buttons.** Pulse `btn_up_out[7]` and `btn_down_out[0]`.
   - `pend_up=pend_down=0`, `dir=IDLE`.
5. **Direction frozen while moving.** Set `dir=UP`, `level=3`, `moving=1`, only `btn_in[1]` pending.
   - `dir` stays 01.
   - Drop `moving` to 0: the next cycle gives `dir=10`, `target=1`.
6. **Reset mid-operation.** With several calls pending, assert `reset=0` between clock edges.
   - All outputs read 0 / IDLE before the next edge.
